// File: rtl/hs_detect_multi_if.sv
// LP line inputs, lane mask and HS status outputs of the multi-lane HS detector.
// master drives the LP lines and mask; slave is the detector.
interface hs_detect_multi_if #(
   parameter int LANES = 4
);
   logic [LANES-1:0] lp_p;
   logic [LANES-1:0] lp_n;
   logic [LANES-1:0] lane_mask;
   logic [LANES-1:0] hs_en;
   logic [LANES-1:0] hs_start;
   logic [LANES-1:0] hs_end;
   logic             all_hs_en;
   logic [LANES-1:0] lp_err;
   logic [LANES-1:0] esc_entry;

   modport master (
      output lp_p, lp_n, lane_mask,
      input  hs_en, hs_start, hs_end, all_hs_en, lp_err, esc_entry
   );

   modport slave (
      input  lp_p, lp_n, lane_mask,
      output hs_en, hs_start, hs_end, all_hs_en, lp_err, esc_entry
   );
endinterface

// File: rtl/hs_detect_multi.sv
// Multi-lane D-PHY LP-11 -> LP-01 -> LP-00 start-of-transmission detector with HS settle timing.
// Defining HS_DETECT_ESC_DETECT_EN adds LP-11 -> LP-10 -> LP-00 escape-entry detection.
module hs_detect_multi #(
   parameter int LANES         = 4,
   parameter int SYNC_STAGES   = 3,
   parameter int SETTLE_CYCLES = 2
) (
   input logic              clk,
   input logic              rst,
   hs_detect_multi_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LP11 = 3'd1,
      ST_LP01 = 3'd2,
      ST_LP00 = 3'd3,
      ST_HS   = 3'd4,
      ST_LP10 = 3'd5
   } lane_state_t;

   localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

   logic [LANES-1:0][SYNC_STAGES-1:0] sync_p;
   logic [LANES-1:0][SYNC_STAGES-1:0] sync_n;
   logic [LANES-1:0][1:0]             lp_data;
   lane_state_t                       state [LANES];
   logic [7:0]                        cnt   [LANES];
   logic [LANES-1:0]                  ev_err;
   logic [LANES-1:0]                  ev_esc;
   logic [LANES-1:0]                  hs_next;
   logic [LANES-1:0]                  hs_en;
   logic [LANES-1:0]                  hs_start;
   logic [LANES-1:0]                  hs_end;
   logic [LANES-1:0]                  lp_err;
   logic [LANES-1:0]                  esc_entry;
   logic                              all_hs_en;

   always_comb begin
      lp_data = '0;
      hs_next = '0;
      for (int i = 0; i < LANES; i++) begin
         lp_data[i] = {sync_p[i][SYNC_STAGES-1], sync_n[i][SYNC_STAGES-1]};
         hs_next[i] = bus.lane_mask[i] && (state[i] == ST_HS);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p <= '0;
         sync_n <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            sync_p[i] <= {sync_p[i][SYNC_STAGES-2:0], bus.lp_p[i]};
            sync_n[i] <= {sync_n[i][SYNC_STAGES-2:0], bus.lp_n[i]};
         end
      end
   end

   // Per-lane sequence FSM; ev_err/ev_esc flag the transition and are presented one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) begin
            state[i] <= ST_IDLE;
            cnt[i]   <= 8'd0;
         end
         ev_err <= '0;
         ev_esc <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            ev_err[i] <= 1'b0;
            ev_esc[i] <= 1'b0;
            if (!bus.lane_mask[i]) begin
               state[i] <= ST_IDLE;
               cnt[i]   <= 8'd0;
            end else begin
               case (state[i])
                  ST_IDLE: begin
                     if (lp_data[i] == 2'b11) state[i] <= ST_LP11;
                     else                     state[i] <= ST_IDLE;
                  end
                  ST_LP11: begin
                     case (lp_data[i])
                        2'b11: state[i] <= ST_LP11;
                        2'b01: state[i] <= ST_LP01;
`ifdef HS_DETECT_ESC_DETECT_EN
                        2'b10: state[i] <= ST_LP10;
`else
                        2'b10: state[i] <= ST_IDLE;
`endif
                        default: begin
                           state[i]  <= ST_IDLE;
                           ev_err[i] <= 1'b1;
                        end
                     endcase
                  end
                  ST_LP01: begin
                     case (lp_data[i])
                        2'b01: state[i] <= ST_LP01;
                        2'b00: begin
                           state[i] <= ST_LP00;
                           cnt[i]   <= 8'd1;
                        end
                        default: begin
                           state[i]  <= ST_IDLE;
                           ev_err[i] <= 1'b1;
                        end
                     endcase
                  end
                  ST_LP00: begin
                     if (lp_data[i] != 2'b00) begin
                        state[i]  <= ST_IDLE;
                        cnt[i]    <= 8'd0;
                        ev_err[i] <= 1'b1;
                     end else if (cnt[i] >= SETTLE) begin
                        state[i] <= ST_HS;
                        cnt[i]   <= 8'd0;
                     end else begin
                        cnt[i] <= (cnt[i] == 8'hFF) ? cnt[i] : cnt[i] + 8'd1;
                     end
                  end
                  ST_HS: begin
                     if (lp_data[i] == 2'b00) state[i] <= ST_HS;
                     else                     state[i] <= ST_IDLE;
                  end
`ifdef HS_DETECT_ESC_DETECT_EN
                  ST_LP10: begin
                     case (lp_data[i])
                        2'b10: state[i] <= ST_LP10;
                        2'b11: state[i] <= ST_LP11;
                        2'b00: begin
                           state[i]  <= ST_IDLE;
                           ev_esc[i] <= 1'b1;
                        end
                        default: begin
                           state[i]  <= ST_IDLE;
                           ev_err[i] <= 1'b1;
                        end
                     endcase
                  end
`endif
                  default: begin
                     state[i] <= ST_IDLE;
                     cnt[i]   <= 8'd0;
                  end
               endcase
            end
         end
      end
   end

   // Registered lane status; masking a lane silences its pulses, including the end pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         hs_en     <= '0;
         hs_start  <= '0;
         hs_end    <= '0;
         lp_err    <= '0;
         esc_entry <= '0;
         all_hs_en <= 1'b0;
      end else begin
         hs_en     <= hs_next;
         hs_start  <= hs_next & ~hs_en;
         hs_end    <= bus.lane_mask & ~hs_next & hs_en;
         lp_err    <= bus.lane_mask & ev_err;
         esc_entry <= bus.lane_mask & ev_esc;
         all_hs_en <= (|bus.lane_mask) && (&(hs_en | ~bus.lane_mask));
      end
   end

   assign bus.hs_en     = hs_en;
   assign bus.hs_start  = hs_start;
   assign bus.hs_end    = hs_end;
   assign bus.lp_err    = lp_err;
   assign bus.esc_entry = esc_entry;
   assign bus.all_hs_en = all_hs_en;

endmodule
